bus_controller: RTL
===================

Name: bus_controller

Overview:
- Sits directly downstream of the CPU bus port (address/data/DV/bhw/write_notread). Accepts one CPU access at a time and decodes it to one of two word-wide slave ports: RAM or IO.
- Performs byte-lane steering and byte enables for stores. Returns loads right-justified and sign- or zero-extended.
- Returns exactly one o_cpu_DV pulse per accepted access, including writes and errors.
- Flags misaligned, unmapped, illegal-size and timed-out accesses.

Parameters:
- RAM_ADDR_W, 14: RAM word-address width. RAM spans byte addresses 0 .. 4*2^RAM_ADDR_W-1.
- IO_BASE, 32'hFFFF_0000: IO region base byte address. Region is 64 KiB.
- IO_ADDR_W, 14: IO word-address width.
- TIMEOUT, 255: maximum cycles to wait for a slave ack. Legal range 1..1023.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cpu_address  in  32  byte address
- i_cpu_data  in  32  store data, right-justified
- i_cpu_DV  in  1  one-cycle request strobe
- i_cpu_bhw  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_cpu_write_notread  in  1  1 = store
- o_cpu_data  out  32  load result
- o_cpu_DV  out  1  one-cycle completion strobe
- o_cpu_err  out  1  valid only with o_cpu_DV; 1 = access failed
- o_busy  out  1  access in flight
- o_ram_req  out  1  RAM request, held until ack
- o_ram_we  out  1  RAM write enable
- o_ram_addr  out  RAM_ADDR_W  RAM word address
- o_ram_be  out  4  RAM byte enables
- o_ram_wdata  out  32  RAM lane-steered write data
- i_ram_rdata  in  32  RAM read word, valid with ack
- i_ram_ack  in  1  RAM completion
- o_io_req, o_io_we, o_io_addr (IO_ADDR_W), o_io_be, o_io_wdata, i_io_rdata, i_io_ack: same as the RAM port, for the IO region

Behaviour:
- Reset, asynchronous on i_rst_n low:
  - State goes to IDLE.
  - All outputs are 0: o_cpu_data, o_cpu_DV, o_cpu_err, o_busy, all req/we/be/addr/wdata.
  - The timeout counter clears.
  - Reset mid-access abandons the access; no o_cpu_DV is produced for it.
- FSM states: IDLE, REQ, RESP, ERR.
- IDLE:
  - On i_cpu_DV, register address, data, bhw and write_notread; o_busy goes to 1 the next cycle.
  - If the access is legal and mapped, go to REQ. Otherwise go to ERR.
  - i_cpu_DV while not in IDLE is ignored; the CPU must wait for o_cpu_DV.
- Decode:
  - RAM: address < 4*2^RAM_ADDR_W.
  - IO: address[31:16] == IO_BASE[31:16].
  - Anything else is unmapped and goes to ERR.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0. Goes to ERR.
  - Illegal bhw (011, 110, 111) goes to ERR.
- REQ:
  - Selected port drives req=1, plus we, word address (addr[ADDR_W+1:2]), be and wdata. All are held stable until ack.
  - Byte enables: B/BU gives be = 1<<addr[1:0]; H/HU gives 0011 or 1100 by addr[1]; W gives 1111.
  - Write data: a byte is replicated to all 4 lanes; a halfword to both halves.
  - On ack, capture rdata and go to RESP. req drops in the cycle after ack.
  - The counter increments each REQ cycle. At count == TIMEOUT with no ack, drop req and go to ERR.
  - An ack arriving in the same cycle as the timeout wins, and the access completes normally.
- RESP:
  - o_cpu_DV=1 and o_cpu_err=0 for exactly one cycle, then go to IDLE.
  - o_busy=0 from the cycle after RESP.
  - Load data: select the lane from addr[1:0], then sign-extend for B/H or zero-extend for BU/HU/W.
  - Stores return o_cpu_data=0.
- ERR:
  - o_cpu_DV=1, o_cpu_err=1, o_cpu_data=0 for one cycle, then go to IDLE.
  - No slave request is issued for decode errors.
- Latency, i_cpu_DV to o_cpu_DV:
  - 2 cycles minimum when ack arrives in the first REQ cycle.
  - 2 cycles for decode errors, passing through ERR.
  - TIMEOUT+2 cycles for a timeout.
- Only one slave req is ever high at a time.
- Acks on the non-selected port, or acks while not in REQ, are ignored.
- o_cpu_data holds its value between strobes.

Decomposition:
- bus_defs.vh holds:
  - BHW_B/H/W/BU/HU codes
  - FSM state encodings
  - default IO_BASE
- Sub-module bus_lane_align (combinational):
  - Store side: byte enables and lane-replicated wdata from addr[1:0] and bhw.
  - Load side: lane select and extension from addr[1:0], bhw and the raw word.
  - It is instantiated once in bus_controller.

Test Plan:
- LW 0x0000_0010, RAM ack in the first REQ cycle with rdata 0xDEADBEEF -> o_ram_addr=4, be=1111, we=0; o_cpu_DV 2 cycles after i_cpu_DV with data 0xDEADBEEF, err=0.
- LB and LBU at 0x0000_0013 with RAM word 0x80FF_0102 -> be=1000; LB returns 0xFFFF_FF80; LBU returns 0x0000_0080.
- SH 0x1234 to IO 0xFFFF_0006 -> io_req with be=1100, wdata=0x1234_1234, we=1, io_addr=1; ack after 3 cycles -> o_cpu_DV err=0, data=0.
- LW 0x0000_0002 (misaligned) and LW 0x8000_0000 (unmapped) -> no req on either port; o_cpu_DV with err=1 after 2 cycles; data=0.
- TIMEOUT=4, RAM never acks -> o_ram_req high for 4 cycles then low; err=1. Repeat with ack on the 4th cycle -> normal completion, err=0.
- i_rst_n pulsed low during REQ -> all outputs 0 immediately; no o_cpu_DV. A new LW after reset completes normally. A second i_cpu_DV while busy is ignored.

Source files
------------

// File: rtl/bus_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_controller_pkg
// Description : Shared definitions for the CPU bus controller: size codes,
//               FSM state encoding, default IO base and decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_controller_pkg;

   // CPU access size codes (i_cpu_bhw)
   localparam logic [2:0] BHW_B  = 3'b000;
   localparam logic [2:0] BHW_H  = 3'b001;
   localparam logic [2:0] BHW_W  = 3'b010;
   localparam logic [2:0] BHW_BU = 3'b100;
   localparam logic [2:0] BHW_HU = 3'b101;

   localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;

   // Wide enough for the largest supported TIMEOUT (1023)
   localparam int TIMEOUT_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   function automatic logic bhw_legal(input logic [2:0] bhw);
      return (bhw == BHW_B) || (bhw == BHW_H) || (bhw == BHW_W) ||
             (bhw == BHW_BU) || (bhw == BHW_HU);
   endfunction

   function automatic logic bhw_misaligned(input logic [2:0] bhw, input logic [1:0] a);
      return (((bhw == BHW_H) || (bhw == BHW_HU)) && a[0]) ||
             ((bhw == BHW_W) && (a != 2'b00));
   endfunction

endpackage
`default_nettype wire

// File: rtl/bus_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : bus_lane_align
// Description : Combinational byte-lane steering.
//               Store side: byte enables and lane-replicated write data.
//               Load side : lane select plus sign/zero extension.
// Ports       : addr_lo_i  - byte offset within the word
//               bhw_i      - access size code
//               st_data_i  - right-justified store data
//               be_o       - byte enables
//               wdata_o    - lane-steered write data
//               ld_word_i  - raw word from the slave
//               ld_data_o  - right-justified, extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module bus_lane_align
   import bus_controller_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  bhw_i,
   input  logic [31:0] st_data_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   input  logic [31:0] ld_word_i,
   output logic [31:0] ld_data_o
);

   logic [7:0]  byte_sel_d;
   logic [15:0] half_sel_d;

   always_comb begin
      be_o    = 4'b0000;
      wdata_o = st_data_i;
      case (bhw_i)
         BHW_B, BHW_BU: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{st_data_i[7:0]}};
         end
         BHW_H, BHW_HU: begin
            be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{st_data_i[15:0]}};
         end
         BHW_W:   be_o = 4'b1111;
         default: be_o = 4'b0000;
      endcase
   end

   always_comb begin
      case (addr_lo_i)
         2'd0:    byte_sel_d = ld_word_i[7:0];
         2'd1:    byte_sel_d = ld_word_i[15:8];
         2'd2:    byte_sel_d = ld_word_i[23:16];
         default: byte_sel_d = ld_word_i[31:24];
      endcase
      half_sel_d = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
      case (bhw_i)
         BHW_B:   ld_data_o = {{24{byte_sel_d[7]}}, byte_sel_d};
         BHW_BU:  ld_data_o = {24'd0, byte_sel_d};
         BHW_H:   ld_data_o = {{16{half_sel_d[15]}}, half_sel_d};
         BHW_HU:  ld_data_o = {16'd0, half_sel_d};
         default: ld_data_o = ld_word_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/bus_controller.sv
`default_nettype none
// ============================================================================
// Module      : bus_controller
// Description : Accepts one CPU access at a time, decodes it to the RAM or
//               IO slave port, steers byte lanes, and returns exactly one
//               o_cpu_DV per accepted access (with o_cpu_err on failure).
// Ports       : i_clk/i_rst_n         - clock, async active-low reset
//               i_cpu_*               - CPU request (address/data/DV/bhw/wnr)
//               o_cpu_data/DV/err     - completion strobe and load result
//               o_busy                - access in flight
//               o_ram_*/i_ram_*       - RAM word port (req held until ack)
//               o_io_*/i_io_*         - IO word port (req held until ack)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_controller
   import bus_controller_pkg::*;
#(
   parameter int          RAM_ADDR_W = 14,
   parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT,
   parameter int          IO_ADDR_W  = 14,
   parameter int          TIMEOUT    = 255
)(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [31:0]           i_cpu_address,
   input  logic [31:0]           i_cpu_data,
   input  logic                  i_cpu_DV,
   input  logic [2:0]            i_cpu_bhw,
   input  logic                  i_cpu_write_notread,
   output logic [31:0]           o_cpu_data,
   output logic                  o_cpu_DV,
   output logic                  o_cpu_err,
   output logic                  o_busy,
   output logic                  o_ram_req,
   output logic                  o_ram_we,
   output logic [RAM_ADDR_W-1:0] o_ram_addr,
   output logic [3:0]            o_ram_be,
   output logic [31:0]           o_ram_wdata,
   input  logic [31:0]           i_ram_rdata,
   input  logic                  i_ram_ack,
   output logic                  o_io_req,
   output logic                  o_io_we,
   output logic [IO_ADDR_W-1:0]  o_io_addr,
   output logic [3:0]            o_io_be,
   output logic [31:0]           o_io_wdata,
   input  logic [31:0]           i_io_rdata,
   input  logic                  i_io_ack
);

   state_e               state_q;
   logic [1:0]           addr_lo_q;
   logic [2:0]           bhw_q;
   logic                 we_q;
   logic                 sel_io_q;
   logic [TIMEOUT_W-1:0] cnt_q;

   logic        is_ram_d, is_io_d, legal_d, ack_d, timeout_d;
   logic [1:0]  lane_addr_d;
   logic [2:0]  lane_bhw_d;
   logic [3:0]  be_d;
   logic [31:0] wdata_d, ld_word_d, ld_data_d;

   assign is_ram_d  = (i_cpu_address >> (RAM_ADDR_W + 2)) == 32'd0;
   assign is_io_d   = (i_cpu_address[31:16] == IO_BASE[31:16]);
   assign legal_d   = bhw_legal(i_cpu_bhw) &&
                      !bhw_misaligned(i_cpu_bhw, i_cpu_address[1:0]) &&
                      (is_ram_d || is_io_d);
   assign ack_d     = sel_io_q ? i_io_ack : i_ram_ack;
   // cnt_q counts completed REQ cycles, so TIMEOUT-1 marks the last one
   assign timeout_d = (cnt_q == TIMEOUT_W'(TIMEOUT - 1));
   assign ld_word_d = sel_io_q ? i_io_rdata : i_ram_rdata;

   // The single aligner serves the store side from the live CPU inputs while
   // idle (port outputs are registered on acceptance) and the load side from
   // the captured access while a request is outstanding.
   assign lane_addr_d = (state_q == ST_IDLE) ? i_cpu_address[1:0] : addr_lo_q;
   assign lane_bhw_d  = (state_q == ST_IDLE) ? i_cpu_bhw : bhw_q;

   bus_lane_align u_lane_align (
      .addr_lo_i (lane_addr_d),
      .bhw_i     (lane_bhw_d),
      .st_data_i (i_cpu_data),
      .be_o      (be_d),
      .wdata_o   (wdata_d),
      .ld_word_i (ld_word_d),
      .ld_data_o (ld_data_d)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         addr_lo_q   <= 2'd0;
         bhw_q       <= 3'd0;
         we_q        <= 1'b0;
         sel_io_q    <= 1'b0;
         cnt_q       <= '0;
         o_cpu_data  <= 32'd0;
         o_cpu_DV    <= 1'b0;
         o_cpu_err   <= 1'b0;
         o_busy      <= 1'b0;
         o_ram_req   <= 1'b0;
         o_ram_we    <= 1'b0;
         o_ram_addr  <= '0;
         o_ram_be    <= 4'd0;
         o_ram_wdata <= 32'd0;
         o_io_req    <= 1'b0;
         o_io_we     <= 1'b0;
         o_io_addr   <= '0;
         o_io_be     <= 4'd0;
         o_io_wdata  <= 32'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               o_cpu_DV  <= 1'b0;
               o_cpu_err <= 1'b0;
               if (i_cpu_DV) begin
                  o_busy    <= 1'b1;
                  addr_lo_q <= i_cpu_address[1:0];
                  bhw_q     <= i_cpu_bhw;
                  we_q      <= i_cpu_write_notread;
                  sel_io_q  <= !is_ram_d;
                  cnt_q     <= '0;
                  if (!legal_d) begin
                     state_q <= ST_ERR;
                  end else if (is_ram_d) begin
                     state_q     <= ST_REQ;
                     o_ram_req   <= 1'b1;
                     o_ram_we    <= i_cpu_write_notread;
                     o_ram_addr  <= i_cpu_address[RAM_ADDR_W+1:2];
                     o_ram_be    <= be_d;
                     o_ram_wdata <= wdata_d;
                  end else begin
                     state_q    <= ST_REQ;
                     o_io_req   <= 1'b1;
                     o_io_we    <= i_cpu_write_notread;
                     o_io_addr  <= i_cpu_address[IO_ADDR_W+1:2];
                     o_io_be    <= be_d;
                     o_io_wdata <= wdata_d;
                  end
               end
            end
            ST_REQ: begin
               if (ack_d || timeout_d) begin
                  o_ram_req   <= 1'b0;
                  o_ram_we    <= 1'b0;
                  o_ram_addr  <= '0;
                  o_ram_be    <= 4'd0;
                  o_ram_wdata <= 32'd0;
                  o_io_req    <= 1'b0;
                  o_io_we     <= 1'b0;
                  o_io_addr   <= '0;
                  o_io_be     <= 4'd0;
                  o_io_wdata  <= 32'd0;
               end
               // An ack coinciding with the timeout still completes normally
               if (ack_d) begin
                  state_q    <= ST_RESP;
                  o_cpu_DV   <= 1'b1;
                  o_cpu_err  <= 1'b0;
                  o_cpu_data <= we_q ? 32'd0 : ld_data_d;
               end else if (timeout_d) begin
                  state_q <= ST_ERR;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RESP: begin
               o_cpu_DV <= 1'b0;
               o_busy   <= 1'b0;
               state_q  <= ST_IDLE;
            end
            ST_ERR: begin
               o_cpu_DV   <= 1'b1;
               o_cpu_err  <= 1'b1;
               o_cpu_data <= 32'd0;
               o_busy     <= 1'b0;
               state_q    <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
